// File: rtl/crc32_job_arbiter.sv
// crc32_job_arbiter: round-robin arbiter sharing one CRC-32 engine among NUM_REQ requesters
module crc32_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [31:0]          resp_crc,
  output logic                 resp_err,
  output logic                 busy,
  output logic [15:0]          jobs_done,
  output logic [31:0]          eng_data,
  output logic                 eng_start,
  output logic                 eng_data_valid,
  input  logic                 eng_ready,
  input  logic                 eng_done,
  input  logic [31:0]          eng_crc
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [ID_W-1:0] rr_ptr, rr_ptr_d, win, win_d, sel, resp_id_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [31:0] eng_data_d, resp_crc_d;
  logic [15:0] jobs_done_d;
  logic eng_start_d, resp_valid_d, resp_err_d, busy_d, fin;
  // first requesting index found ascending from rr_ptr, wrapping
  always_comb begin
    sel = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % NUM_REQ]) sel = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
  end
  // next state and next registered outputs
  always_comb begin
    state_d = state;
    rr_ptr_d = rr_ptr;
    win_d = win;
    cnt_d = cnt;
    eng_data_d = eng_data;
    grant_d = '0;
    eng_start_d = 1'b0;
    resp_valid_d = 1'b0;
    resp_id_d = resp_id;
    resp_crc_d = resp_crc;
    resp_err_d = resp_err;
    jobs_done_d = jobs_done;
    fin = 1'b0;
    case (state)
      IDLE: if (|req && eng_ready) begin
        state_d = ISSUE;
        win_d = sel;
        eng_data_d = req_data[32*int'(sel) +: 32];
        grant_d = NUM_REQ'(1) << sel;
        eng_start_d = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt + 1'b1;
        fin = eng_done || cnt == CW'(TIMEOUT - 1);
        if (fin) begin
          state_d = RESP;
          resp_valid_d = 1'b1;
          resp_id_d = win;
          resp_crc_d = eng_done ? eng_crc : '0;
          resp_err_d = !eng_done;
          jobs_done_d = jobs_done + 1'b1;
          rr_ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      win <= '0;
      cnt <= '0;
      grant <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_crc <= '0;
      resp_err <= 1'b0;
      busy <= 1'b0;
      jobs_done <= '0;
      eng_data <= '0;
      eng_start <= 1'b0;
      eng_data_valid <= 1'b0;
    end else begin
      state <= state_d;
      rr_ptr <= rr_ptr_d;
      win <= win_d;
      cnt <= cnt_d;
      grant <= grant_d;
      resp_valid <= resp_valid_d;
      resp_id <= resp_id_d;
      resp_crc <= resp_crc_d;
      resp_err <= resp_err_d;
      busy <= busy_d;
      jobs_done <= jobs_done_d;
      eng_data <= eng_data_d;
      eng_start <= eng_start_d;
      eng_data_valid <= eng_start_d;
    end
  end
endmodule

// File: tb/tb_crc32_job_arbiter.sv
// tb_crc32_job_arbiter: randomized scoreboard bench with a behavioural CRC engine
module tb_crc32_job_arbiter;
  localparam int N = 4;
  localparam int TO = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0] grant;
  logic resp_valid, resp_err, busy, eng_start, eng_data_valid;
  logic [1:0] resp_id;
  logic [31:0] resp_crc, eng_data;
  logic [15:0] jobs_done;
  logic eng_ready = 1'b0, eng_done = 1'b0;
  logic [31:0] eng_crc = '0;
  typedef struct {logic [N-1:0] g; int id; logic [31:0] d; logic [31:0] c; bit e;} job_t;
  job_t gq[$], rq[$];
  int n_tests = 0, n_fail = 0, cyc = 0, gcyc = 0, model_ptr = 0, rearm_left = 0, lat_cfg = 0, resp_seen = 0;
  bit hang = 0, block_en = 0, late_done = 0, jobs_chk = 0;
  logic [15:0] model_jobs = '0;

  crc32_job_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_crc(resp_crc), .resp_err(resp_err),
    .busy(busy), .jobs_done(jobs_done), .eng_data(eng_data), .eng_start(eng_start),
    .eng_data_valid(eng_data_valid), .eng_ready(eng_ready), .eng_done(eng_done), .eng_crc(eng_crc)
  );

  always #5 clk = ~clk;

  // standard reflected CRC-32 of one word, bytes LSB first
  function automatic logic [31:0] crc32(input logic [31:0] d);
    logic [31:0] c = '1;
    for (int i = 0; i < 32; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int next_winner(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  function automatic void expect_job(input int w, input logic [31:0] d, input logic [31:0] c, input bit e, input bit resp);
    job_t j;
    j.g = '0;
    j.g[w] = 1'b1;
    j.id = w;
    j.d = d;
    j.c = c;
    j.e = e;
    gq.push_back(j);
    if (resp) begin
      rq.push_back(j);
      model_ptr = (w + 1) % N;
    end
  endfunction

  task automatic check_zero();
    check("rst_grant", grant, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_crc", resp_crc, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_eng_data", eng_data, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_data_valid", eng_data_valid, 0);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while ((gq.size() + rq.size()) > 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if ((gq.size() + rq.size()) > 0) begin
      check("drain_timeout", gq.size() + rq.size(), 0);
      gq.delete();
      rq.delete();
    end
    repeat (2) @(negedge clk);
    check("busy_between_jobs", busy, 0);
  endtask

  task automatic run_direct(input int i, input logic [31:0] d, input logic [31:0] c);
    @(negedge clk);
    #1;
    req_data[32*i +: 32] = d;
    expect_job(i, d, c, 1'b0, 1'b1);
    req[i] = 1'b1;
    wait_done(500);
  endtask

  task automatic run_batch(input logic [N-1:0] mask, input int rearms);
    logic [N-1:0] m = mask;
    int r = rearms;
    logic [31:0] d [N];
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      d[i] = $urandom;
      req_data[32*i +: 32] = d[i];
    end
    repeat ($countones(mask) + rearms) begin
      int w = next_winner(m, model_ptr);
      expect_job(w, d[w], hang ? 32'h0 : crc32(d[w]), hang, 1'b1);
      if (r > 0) r--;
      else m[w] = 1'b0;
    end
    rearm_left = rearms;
    req = mask;
    wait_done(4000);
  endtask

  // behavioural engine: variable latency, optional hang, optional ready stalls
  initial begin
    logic st, r, blk, eb;
    logic [31:0] d, ew;
    int ecnt;
    eb = 0;
    ew = '0;
    ecnt = 0;
    forever begin
      @(negedge clk);
      st = eng_start;
      d = eng_data;
      r = rst_n;
      #1;
      eng_done = 1'b0;
      if (!r) eb = 0;
      else if (late_done) begin
        eng_done = 1'b1;
        eng_crc = 32'hDEADBEEF;
        late_done = 0;
      end else if (st) begin
        eb = 1;
        ecnt = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 20));
        ew = d;
      end else if (eb) begin
        ecnt--;
        if (ecnt == 0) begin
          eb = 0;
          if (!hang) begin
            eng_done = 1'b1;
            eng_crc = crc32(ew);
          end
        end
      end
      blk = block_en && ($urandom_range(0, 3) == 0);
      eng_ready = !eb && !blk && r;
    end
  end

  // requesters: drop on grant, re-raise after response while re-arms remain
  initial begin
    logic [N-1:0] g;
    logic rv;
    logic [1:0] rid;
    forever begin
      @(negedge clk);
      g = grant;
      rv = resp_valid;
      rid = resp_id;
      #1;
      if (rst_n) begin
        req = req & ~g;
        if (rv && rearm_left > 0) begin
          req[rid] = 1'b1;
          rearm_left--;
        end
      end
    end
  end

  // monitor: pops expected grants and responses as the DUT presents them
  initial begin
    job_t j;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) jobs_chk = 0;
      else begin
        if (jobs_chk) begin
          check("jobs_done", jobs_done, model_jobs);
          jobs_chk = 0;
        end
        if (|grant || eng_start || eng_data_valid) begin
          if (gq.size() == 0) check("unexpected_issue", {grant, eng_start, eng_data_valid}, 0);
          else begin
            j = gq.pop_front();
            check("grant", grant, j.g);
            check("eng_start", eng_start, 1);
            check("eng_data_valid", eng_data_valid, 1);
            check("eng_data", eng_data, j.d);
            check("ready_at_select", eng_ready, 1);
            check("busy_issue", busy, 1);
            gcyc = cyc;
          end
        end
        if (resp_valid) begin
          resp_seen++;
          if (rq.size() == 0) check("unexpected_resp", resp_valid, 0);
          else begin
            j = rq.pop_front();
            check("resp_id", resp_id, j.id);
            check("resp_crc", resp_crc, j.c);
            check("resp_err", resp_err, j.e);
            check("busy_resp", busy, 1);
            if (j.e) check("timeout_latency", cyc - gcyc, TO + 1);
            model_jobs++;
            jobs_chk = 1;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int r0, n;
    repeat (3) @(negedge clk);
    check_zero();
    #1 rst_n = 1'b1;
    run_direct(0, 32'h00000000, 32'h2144DF1C);
    run_direct(1, 32'h34333231, 32'h9BE3E0A3);
    run_batch(4'b1111, 0);
    d = $urandom;
    run_direct(1, d, crc32(d));
    run_batch(4'b1011, 1);
    hang = 1;
    run_batch(4'b0001, 0);
    r0 = resp_seen;
    @(negedge clk);
    #1 late_done = 1;
    repeat (6) @(negedge clk);
    check("late_done_ignored", resp_seen, r0);
    hang = 0;
    block_en = 1;
    repeat (30) run_batch(N'($urandom_range(1, 15)), $urandom_range(0, 3));
    block_en = 0;
    lat_cfg = 30;
    @(negedge clk);
    #1;
    d = $urandom;
    req_data[31:0] = d;
    expect_job(0, d, crc32(d), 1'b0, 1'b0);
    req = 4'b0001;
    n = 0;
    while (gq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abandoned_grant_seen", gq.size(), 0);
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    rearm_left = 0;
    req = '0;
    gq.delete();
    rq.delete();
    model_ptr = 0;
    model_jobs = '0;
    @(negedge clk);
    check_zero();
    #1;
    rst_n = 1'b1;
    lat_cfg = 0;
    d = $urandom;
    run_direct(2, d, crc32(d));
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/crc32_job_arbiter.md
Name: crc32_job_arbiter

Overview:
- Shares one crc32_calculator engine among NUM_REQ requesters using round-robin arbitration.
- Latches the winner's 32-bit word and issues it to the engine with a one-cycle start/data_valid pulse.
- Waits for the engine's done pulse, then returns the CRC to the winner, tagged with its requester ID.
- Sits between the requesting datapath blocks and the single CRC engine instance; also provides a timeout guard and a job counter.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT, 64, max cycles in WAIT before an error response; must be at least 48.
- ID_W, derived localparam = clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester job request; level, held until grant.
- req_data  in  32*NUM_REQ  requester i's word at [32*i+31:32*i].
- grant  out  NUM_REQ  one-hot; 1-cycle pulse acknowledging the latched job.
- resp_valid  out  1  1-cycle pulse; result available.
- resp_id  out  ID_W  requester the response belongs to.
- resp_crc  out  32  CRC result; 0 on error.
- resp_err  out  1  qualifies resp_valid; 1 = engine timeout.
- busy  out  1  high in any state except IDLE.
- jobs_done  out  16  count of resp_valid pulses; wraps 0xFFFF->0.
- eng_data  out  32  to engine data_in.
- eng_start  out  1  to engine start.
- eng_data_valid  out  1  to engine data_valid.
- eng_ready  in  1  from engine ready.
- eng_done  in  1  from engine done.
- eng_crc  in  32  from engine crc_out.

Behaviour:
- Reset (rst_n=0 at posedge) clears everything to 0: all outputs, state=IDLE, rr_ptr=0, timeout counter, latched data and ID. Reset mid-job abandons the job with no response. The engine shares rst_n.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Selection happens when |req and eng_ready.
  - Search starts at rr_ptr and runs ascending, modulo NUM_REQ; the first set bit is the winner w.
  - Latch req_data[w] and w, then go to ISSUE.
  - With no request, or eng_ready=0, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - eng_start=1, eng_data_valid=1, eng_data=latched word.
  - grant[w]=1; all other grant bits 0.
  - Clear the timeout counter and go to WAIT.
  - eng_start and eng_data_valid are 0 in every other state.
- WAIT:
  - Counter increments every cycle.
  - If eng_done=1: latch eng_crc, set err=0, go to RESP. eng_done takes priority over timeout in the same cycle.
  - Else if counter==TIMEOUT-1: set crc=0, err=1, go to RESP.
- RESP (exactly 1 cycle):
  - resp_valid=1, resp_id=w, resp_crc and resp_err from latched values.
  - jobs_done+1.
  - rr_ptr=(w+1) mod NUM_REQ.
  - Go to IDLE.
- resp_id, resp_crc and resp_err hold their values after the pulse until the next RESP.
- Requester data is sampled only in the selection cycle. A requester must deassert req in the cycle after its grant, or it re-requests.
- Dropping req before grant is legal; that requester simply is not selected.
- eng_done seen outside WAIT (for example, late after a timeout) is ignored.
- Minimum turnaround: one job every (engine latency + 3) cycles. Back-to-back jobs re-enter selection from IDLE on the cycle after RESP.
- The controller never issues while eng_ready=0.

Test Plan:
- After reset, check all outputs are 0. Then req=0001, req_data[0]=32'h00000000 -> grant=0001 for 1 cycle, a single eng_start pulse, then resp_valid with resp_id=0, resp_crc=32'h2144DF1C, resp_err=0, jobs_done=1.
- req=0010, data 32'h34333231 (ASCII "1234", LSB byte first) -> resp_id=1, resp_crc=32'h9BE3E0A3.
- req=1111 asserted together from reset, each dropped after its grant -> grants in order 0001, 0010, 0100, 1000; four responses with ids 0, 1, 2, 3; jobs_done=4; busy low only between jobs.
- Fairness with rr_ptr=2: req=1011 held (each requester re-raises req after its response) -> service order 3, 0, 1, 3; requester 1 is never skipped twice.
- Stub engine with done tied to 0 -> resp_valid exactly TIMEOUT cycles after the WAIT entry edge, with resp_err=1, resp_crc=0. A late done pulse in the following IDLE produces no response.
- rst_n=0 for 1 cycle while in WAIT -> all outputs 0 next cycle and no resp_valid. A following job completes normally with a correct CRC.
